// File: rtl/sarray_ldst_ctrl.sv
// Tile load/store sequencer for the systolic array: row reads, ping-pong A buffer, array feed
// and STOREC drain. Optional perf counters under `SARRAY_LDST_PERF_EN.
module sarray_ldst_ctrl #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 256,
   parameter int unsigned BEATS   = 64,
   parameter int unsigned STRIDE  = 256,
   parameter int unsigned MAX_OUT = 8,
   parameter int unsigned PREC_W  = 2,
   localparam int unsigned CNT_W  = $clog2(BEATS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tinst_valid_i,
   output logic              tinst_ready_o,
   input  logic [1:0]        tinst_type_i,
   input  logic [ADDR_W-1:0] tinst_addr0_i,
   input  logic [ADDR_W-1:0] tinst_addr1_i,
   input  logic [PREC_W-1:0] tinst_precision_i,
   input  logic              tinst_acc_i,
   output logic              ar_valid_o,
   input  logic              ar_ready_i,
   output logic [ADDR_W-1:0] ar_addr_o,
   input  logic              r_valid_i,
   output logic              r_ready_o,
   input  logic [DATA_W-1:0] r_data_i,
   output logic              aw_valid_o,
   input  logic              aw_ready_i,
   output logic [ADDR_W-1:0] aw_addr_o,
   output logic [DATA_W-1:0] aw_data_o,
   output logic              feed_valid_o,
   output logic              feed_type_o,
   output logic [CNT_W-1:0]  feed_cnt_o,
   output logic [PREC_W-1:0] feed_precision_o,
   output logic              feed_acc_o,
   output logic [DATA_W-1:0] feed_left_data_o,
   output logic [DATA_W-1:0] feed_top_data_o,
   input  logic              res_valid_i,
   output logic              res_ready_o,
   input  logic [DATA_W-1:0] res_data_i,
`ifdef SARRAY_LDST_PERF_EN
   output logic [31:0]       perf_busy_o,
   output logic [31:0]       perf_ar_stall_o,
`endif
   output logic              done_o
);

   localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StLoad  = 2'd1;
   localparam logic [1:0] StStore = 2'd2;

   localparam logic [1:0] TyTmma  = 2'd0;
   localparam logic [1:0] TyPreA  = 2'd1;
   localparam logic [1:0] TyPreC  = 2'd2;
   localparam logic [1:0] TyStore = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [1:0]        type_q, type_d;
   logic [ADDR_W-1:0] addr0_q, addr0_d;
   logic [ADDR_W-1:0] addr1_q, addr1_d;
   logic [PREC_W-1:0] prec_q, prec_d;
   logic              acc_q, acc_d;
   logic [CNT_W:0]    ar_cnt_q, ar_cnt_d;
   logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
   logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
   logic [OUT_W-1:0]  out_q, out_d;
   logic              rd_bank_q, rd_bank_d;
   logic              a_valid_q, a_valid_d;
   logic              done_q, done_d;

   // Two banks of BEATS rows; bank index is the MSB of the address. Not reset.
   logic [DATA_W-1:0] a_mem [2*BEATS];

   logic              in_load, in_store;
   logic              ar_hs, r_hs, w_hs, r_last, w_last, ar_pending;
   logic [ADDR_W-1:0] rd_base;

   assign in_load    = (state_q == StLoad);
   assign in_store   = (state_q == StStore);
   assign ar_pending = in_load && (32'(ar_cnt_q) < BEATS);
   assign ar_valid_o = ar_pending && (32'(out_q) < MAX_OUT);
   assign ar_hs      = ar_valid_o && ar_ready_i;
   assign r_ready_o  = in_load;
   assign r_hs       = in_load && r_valid_i;
   assign r_last     = r_hs && (r_cnt_q == CNT_W'(BEATS - 1));
   assign aw_valid_o = in_store && res_valid_i;
   assign res_ready_o = in_store && aw_ready_i;
   assign w_hs       = in_store && res_valid_i && aw_ready_i;
   assign w_last     = w_hs && (w_cnt_q == CNT_W'(BEATS - 1));
   assign rd_base    = (type_q == TyTmma) ? addr1_q : addr0_q;

   assign ar_addr_o  = in_load ? rd_base + ADDR_W'(ar_cnt_q) * ADDR_W'(STRIDE) : '0;
   assign aw_addr_o  = in_store ? addr0_q + ADDR_W'(w_cnt_q) * ADDR_W'(STRIDE) : '0;
   assign aw_data_o  = in_store ? res_data_i : '0;

   assign tinst_ready_o    = (state_q == StIdle);
   assign done_o           = done_q;
   assign feed_precision_o = prec_q;
   assign feed_acc_o       = acc_q;

   // PRELOADA beats only fill the shadow bank; every other load streams into the array.
   assign feed_valid_o = r_hs && (type_q != TyPreA);
   assign feed_type_o  = feed_valid_o && (type_q == TyPreC);
   assign feed_cnt_o   = feed_valid_o ? r_cnt_q : '0;

   always_comb begin
      feed_left_data_o = '0;
      feed_top_data_o  = '0;
      if (feed_valid_o) begin
         if (type_q == TyPreC) begin
            feed_left_data_o = r_data_i;
         end else begin
            feed_top_data_o = r_data_i;
            if (a_valid_q) feed_left_data_o = a_mem[{rd_bank_q, r_cnt_q}];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_hs && (type_q == TyPreA)) a_mem[{~rd_bank_q, r_cnt_q}] <= r_data_i;
   end

   always_comb begin
      state_d   = state_q;
      type_d    = type_q;
      addr0_d   = addr0_q;
      addr1_d   = addr1_q;
      prec_d    = prec_q;
      acc_d     = acc_q;
      ar_cnt_d  = ar_cnt_q;
      r_cnt_d   = r_cnt_q;
      w_cnt_d   = w_cnt_q;
      out_d     = out_q;
      rd_bank_d = rd_bank_q;
      a_valid_d = a_valid_q;
      done_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (tinst_valid_i) begin
               type_d  = tinst_type_i;
               addr0_d = tinst_addr0_i;
               addr1_d = tinst_addr1_i;
               prec_d  = tinst_precision_i;
               acc_d   = tinst_acc_i;
               state_d = (tinst_type_i == TyStore) ? StStore : StLoad;
            end
         end
         StLoad: begin
            if (ar_hs) ar_cnt_d = ar_cnt_q + 1'b1;
            if (r_hs) r_cnt_d = r_cnt_q + 1'b1;
            if (ar_hs && !r_hs) out_d = out_q + 1'b1;
            else if (!ar_hs && r_hs) out_d = out_q - 1'b1;
            if (r_last) begin
               state_d  = StIdle;
               ar_cnt_d = '0;
               r_cnt_d  = '0;
               out_d    = '0;
               done_d   = 1'b1;
               if (type_q == TyPreA) begin
                  rd_bank_d = ~rd_bank_q;
                  a_valid_d = 1'b1;
               end
            end
         end
         StStore: begin
            if (w_hs) w_cnt_d = w_cnt_q + 1'b1;
            if (w_last) begin
               state_d = StIdle;
               w_cnt_d = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         type_q    <= TyTmma;
         addr0_q   <= '0;
         addr1_q   <= '0;
         prec_q    <= '0;
         acc_q     <= 1'b0;
         ar_cnt_q  <= '0;
         r_cnt_q   <= '0;
         w_cnt_q   <= '0;
         out_q     <= '0;
         rd_bank_q <= 1'b0;
         a_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         type_q    <= type_d;
         addr0_q   <= addr0_d;
         addr1_q   <= addr1_d;
         prec_q    <= prec_d;
         acc_q     <= acc_d;
         ar_cnt_q  <= ar_cnt_d;
         r_cnt_q   <= r_cnt_d;
         w_cnt_q   <= w_cnt_d;
         out_q     <= out_d;
         rd_bank_q <= rd_bank_d;
         a_valid_q <= a_valid_d;
         done_q    <= done_d;
      end
   end

`ifdef SARRAY_LDST_PERF_EN
   logic [31:0] busy_q, busy_d, stall_q, stall_d;

   always_comb begin
      busy_d  = busy_q;
      stall_d = stall_q;
      if ((state_q != StIdle) && (busy_q != 32'hFFFF_FFFF)) busy_d = busy_q + 32'd1;
      // A pending row that does not handshake counts, whether MAX_OUT or ar_ready_i blocked it.
      if (ar_pending && !ar_hs && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         stall_q <= '0;
      end else begin
         busy_q  <= busy_d;
         stall_q <= stall_d;
      end
   end

   assign perf_busy_o     = busy_q;
   assign perf_ar_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_sarray_ldst_ctrl.sv
// Directed bench for sarray_ldst_ctrl: preloads, TMMA feed, MAX_OUT throttling, STOREC drain
// and asynchronous reset mid-operation.
module tb_sarray_ldst_ctrl;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 256;
   localparam int unsigned BEATS  = 64;
   localparam int unsigned CNT_W  = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              tinst_valid_i = 1'b0;
   logic              tinst_ready_o;
   logic [1:0]        tinst_type_i = '0;
   logic [ADDR_W-1:0] tinst_addr0_i = '0;
   logic [ADDR_W-1:0] tinst_addr1_i = '0;
   logic [1:0]        tinst_precision_i = '0;
   logic              tinst_acc_i = 1'b0;
   logic              ar_valid_o;
   logic              ar_ready_i = 1'b1;
   logic [ADDR_W-1:0] ar_addr_o;
   logic              r_valid_i = 1'b0;
   logic              r_ready_o;
   logic [DATA_W-1:0] r_data_i = '0;
   logic              aw_valid_o;
   logic              aw_ready_i = 1'b0;
   logic [ADDR_W-1:0] aw_addr_o;
   logic [DATA_W-1:0] aw_data_o;
   logic              feed_valid_o;
   logic              feed_type_o;
   logic [CNT_W-1:0]  feed_cnt_o;
   logic [1:0]        feed_precision_o;
   logic              feed_acc_o;
   logic [DATA_W-1:0] feed_left_data_o;
   logic [DATA_W-1:0] feed_top_data_o;
   logic              res_valid_i = 1'b0;
   logic              res_ready_o;
   logic [DATA_W-1:0] res_data_i = '0;
   logic              done_o;
`ifdef SARRAY_LDST_PERF_EN
   logic [31:0]       perf_busy_o;
   logic [31:0]       perf_ar_stall_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference copy of the most recently completed PRELOADA.
   logic [DATA_W-1:0] a_model [BEATS];
   bit                a_vld = 1'b0;

   always #5 clk = ~clk;

   sarray_ldst_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .BEATS  (BEATS),
      .STRIDE (256),
      .MAX_OUT(8),
      .PREC_W (2)
   ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .tinst_valid_i    (tinst_valid_i),
      .tinst_ready_o    (tinst_ready_o),
      .tinst_type_i     (tinst_type_i),
      .tinst_addr0_i    (tinst_addr0_i),
      .tinst_addr1_i    (tinst_addr1_i),
      .tinst_precision_i(tinst_precision_i),
      .tinst_acc_i      (tinst_acc_i),
      .ar_valid_o       (ar_valid_o),
      .ar_ready_i       (ar_ready_i),
      .ar_addr_o        (ar_addr_o),
      .r_valid_i        (r_valid_i),
      .r_ready_o        (r_ready_o),
      .r_data_i         (r_data_i),
      .aw_valid_o       (aw_valid_o),
      .aw_ready_i       (aw_ready_i),
      .aw_addr_o        (aw_addr_o),
      .aw_data_o        (aw_data_o),
      .feed_valid_o     (feed_valid_o),
      .feed_type_o      (feed_type_o),
      .feed_cnt_o       (feed_cnt_o),
      .feed_precision_o (feed_precision_o),
      .feed_acc_o       (feed_acc_o),
      .feed_left_data_o (feed_left_data_o),
      .feed_top_data_o  (feed_top_data_o),
      .res_valid_i      (res_valid_i),
      .res_ready_o      (res_ready_o),
      .res_data_i       (res_data_i),
`ifdef SARRAY_LDST_PERF_EN
      .perf_busy_o      (perf_busy_o),
      .perf_ar_stall_o  (perf_ar_stall_o),
`endif
      .done_o           (done_o)
   );

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] pat(input int seed, input int k, input bit inv);
      logic [255:0] v;
      v = {32'(seed), 192'd0, 32'(k)};
      return inv ? ~v : v;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_tinst_ready"}, 256'(tinst_ready_o), 256'(1));
      check_eq({tag, "_ar_valid"}, 256'(ar_valid_o), 256'(0));
      check_eq({tag, "_r_ready"}, 256'(r_ready_o), 256'(0));
      check_eq({tag, "_aw_valid"}, 256'(aw_valid_o), 256'(0));
      check_eq({tag, "_res_ready"}, 256'(res_ready_o), 256'(0));
      check_eq({tag, "_feed_valid"}, 256'(feed_valid_o), 256'(0));
      check_eq({tag, "_ar_addr"}, 256'(ar_addr_o), 256'(0));
      check_eq({tag, "_feed_left"}, feed_left_data_o, 256'(0));
   endtask

   task automatic issue(input logic [1:0] ty, input logic [63:0] a, input logic [1:0] p,
                        input logic acc);
      @(posedge clk); #1;
      tinst_valid_i     = 1'b1;
      tinst_type_i      = ty;
      // The unused base carries junk so a wrong base selection shows up in the addresses.
      tinst_addr0_i     = (ty == 2'd0) ? 64'hDEAD_0000 : a;
      tinst_addr1_i     = (ty == 2'd0) ? a : 64'hBEEF_0000;
      tinst_precision_i = p;
      tinst_acc_i       = acc;
      #1;
      check_eq("issue_ready", 256'(tinst_ready_o), 256'(1));
   endtask

   task automatic check_done();
      @(posedge clk); #1;
      r_valid_i   = 1'b0;
      res_valid_i = 1'b0;
      #1;
      check_eq("done_pulse", 256'(done_o), 256'(1));
      check_eq("done_ready", 256'(tinst_ready_o), 256'(1));
      @(posedge clk); #2;
      check_eq("done_clear", 256'(done_o), 256'(0));
   endtask

   // Load-type instruction with an in-order memory responder. stall: cycles with r_valid held 0.
   // rst_at >= 0: assert reset right after that R beat is sampled.
   task automatic run_load(input logic [1:0] ty, input logic [63:0] addr, input int seed,
                           input bit inv, input int stall, input int rst_at);
      int ar_k, r_k, outs, cyc;
      logic [255:0] d, el;
      logic [255:0] pend [BEATS];
      issue(ty, addr, 2'b10, 1'b1);
      ar_k = 0; r_k = 0; outs = 0; cyc = 0;
      ar_ready_i = 1'b1;
      while (r_k < 64 && cyc < 1000) begin
         @(posedge clk); #1;
         tinst_valid_i = 1'b0;
         r_valid_i = (outs > 0) && (cyc >= stall);
         d = pat(seed, r_k, inv);
         r_data_i = d;
         #1;
         if (stall > 0 && cyc == stall) check_eq("ar_hs_at_max_out", 256'(ar_k), 256'(8));
         check_eq("ar_valid", 256'(ar_valid_o), 256'(ar_k < 64 && outs < 8));
         if (ar_valid_o) check_eq("ar_addr", 256'(ar_addr_o), 256'(addr + 64'(ar_k) * 64'h100));
         check_eq("r_ready", 256'(r_ready_o), 256'(1));
         if (r_valid_i) begin
            if (ty == 2'd1) begin
               check_eq("feed_valid_prea", 256'(feed_valid_o), 256'(0));
            end else begin
               el = (ty == 2'd2) ? d : (a_vld ? a_model[r_k] : 256'(0));
               check_eq("feed_valid", 256'(feed_valid_o), 256'(1));
               check_eq("feed_type", 256'(feed_type_o), 256'(ty == 2'd2));
               check_eq("feed_cnt", 256'(feed_cnt_o), 256'(r_k));
               check_eq("feed_left", feed_left_data_o, el);
               check_eq("feed_top", feed_top_data_o, (ty == 2'd0) ? d : 256'(0));
               if (r_k == 0) begin
                  check_eq("feed_prec", 256'(feed_precision_o), 256'(2));
                  check_eq("feed_acc", 256'(feed_acc_o), 256'(1));
               end
            end
            pend[r_k] = d;
         end else begin
            check_eq("feed_idle", 256'(feed_valid_o), 256'(0));
         end
         if (rst_at >= 0 && r_valid_i && r_k == rst_at) begin
            rst_n = 1'b0;
            #1;
            check_idle_outputs("async_rst");
            check_eq("async_rst_done", 256'(done_o), 256'(0));
            repeat (2) @(posedge clk);
            #1;
            check_idle_outputs("in_rst");
            rst_n = 1'b0;
            r_valid_i = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #2;
            check_idle_outputs("post_rst");
            a_vld = 1'b0;
            return;
         end
         if (ar_k < 64 && outs < 8) begin
            ar_k++;
            outs++;
         end
         if (r_valid_i) begin
            r_k++;
            outs--;
         end
         cyc++;
      end
      check_eq("load_beats", 256'(r_k), 256'(64));
      check_eq("load_ar_total", 256'(ar_k), 256'(64));
      check_done();
      if (ty == 2'd1) begin
         for (int i = 0; i < BEATS; i++) a_model[i] = pend[i];
         a_vld = 1'b1;
      end
   endtask

   task automatic run_store(input logic [63:0] addr, input int seed);
      int w_k, cyc;
      issue(2'd3, addr, 2'b00, 1'b0);
      w_k = 0; cyc = 0;
      while (w_k < 64 && cyc < 2000) begin
         @(posedge clk); #1;
         tinst_valid_i = 1'b0;
         res_valid_i   = 1'($urandom_range(0, 1));
         aw_ready_i    = 1'($urandom_range(0, 1));
         res_data_i    = pat(seed, w_k, 1'b0);
         #1;
         check_eq("aw_valid", 256'(aw_valid_o), 256'(res_valid_i));
         check_eq("res_ready", 256'(res_ready_o), 256'(aw_ready_i));
         check_eq("store_ar_valid", 256'(ar_valid_o), 256'(0));
         check_eq("store_feed", 256'(feed_valid_o), 256'(0));
         if (res_valid_i) begin
            check_eq("aw_addr", 256'(aw_addr_o), 256'(addr + 64'(w_k) * 64'h100));
            check_eq("aw_data", aw_data_o, pat(seed, w_k, 1'b0));
         end
         if (res_valid_i && aw_ready_i) w_k++;
         cyc++;
      end
      check_eq("store_beats", 256'(w_k), 256'(64));
      check_done();
   endtask

   initial begin
      #1;
      check_idle_outputs("reset");
      check_eq("reset_done", 256'(done_o), 256'(0));
      check_eq("reset_prec", 256'(feed_precision_o), 256'(0));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #2;
      check_idle_outputs("after_release");

      run_load(2'd0, 64'h8000, 5, 1'b0, 0, -1);   // TMMA with no valid A: left = 0
      run_load(2'd1, 64'h1000, 0, 1'b0, 0, -1);   // PRELOADA rows k = k
      run_load(2'd0, 64'h8000, 0, 1'b1, 0, -1);   // TMMA top = ~k, left = k
      run_load(2'd1, 64'h3000, 7, 1'b0, 20, -1);  // PRELOADA throttled by MAX_OUT
      run_load(2'd0, 64'h9000, 3, 1'b1, 0, -1);   // TMMA sees the new bank
      run_load(2'd2, 64'h5000, 9, 1'b0, 0, -1);   // PRELOADC
      run_store(64'h2000, 11);
      run_load(2'd0, 64'h8000, 4, 1'b0, 0, 30);   // reset at beat 30
      run_load(2'd0, 64'hA000, 2, 1'b0, 0, -1);   // a_valid cleared by reset

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sarray_ldst_ctrl.md
Name: sarray_ldst_ctrl

Overview:
- Parametrised tile load/store sequencer for the systolic array. It accepts one tile instruction at a time: TMMA, PRELOADA, PRELOADC or STOREC.
- It issues per-row read/write requests with a configurable row count, stride and number of outstanding reads.
- It holds a ping-pong A-operand buffer and drives the array's left/top feed.
- It adds a STOREC drain path that writes array results back to memory.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 256, bits per row beat (load and store).
- BEATS, 64, rows per tile (power of 2, ≥2); CNT_W = clog2(BEATS).
- STRIDE, 256, byte address increment per row.
- MAX_OUT, 8, maximum outstanding reads (AR accepted, R not yet received).
- PREC_W, 2, precision field width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tinst_valid_i  in  1  instruction valid
- tinst_ready_o  out  1  instruction ready
- tinst_type_i  in  2  0=TMMA, 1=PRELOADA, 2=PRELOADC, 3=STOREC
- tinst_addr0_i  in  ADDR_W  base for PRELOADA/PRELOADC/STOREC
- tinst_addr1_i  in  ADDR_W  B-operand base for TMMA
- tinst_precision_i  in  PREC_W  MMA precision
- tinst_acc_i  in  1  accumulate flag
- ar_valid_o  out  1  read request valid
- ar_ready_i  in  1  read request ready
- ar_addr_o  out  ADDR_W  read address
- r_valid_i  in  1  read data valid
- r_ready_o  out  1  read data ready
- r_data_i  in  DATA_W  read data
- aw_valid_o  out  1  write valid
- aw_ready_i  in  1  write ready
- aw_addr_o  out  ADDR_W  write address
- aw_data_o  out  DATA_W  write data
- feed_valid_o  out  1  array feed valid
- feed_type_o  out  1  0=MMA row, 1=C preload row
- feed_cnt_o  out  CNT_W  row index
- feed_precision_o  out  PREC_W  latched precision
- feed_acc_o  out  1  latched acc flag
- feed_left_data_o  out  DATA_W  left (A or C) row
- feed_top_data_o  out  DATA_W  top (B) row
- res_valid_i  in  1  array result row valid
- res_ready_o  out  1  array result row ready
- res_data_i  in  DATA_W  array result row
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; all counters 0; rd_bank=0; a_valid=0. Every valid, ready and done output is 0 except tinst_ready_o, which is 1. Data outputs are 0.
- States:
  - IDLE: tinst_ready_o=1. On handshake, latch type/addr/precision/acc. Go to LOAD (types 0–2) or STORE (type 3) next cycle.
  - LOAD:
    - ar_valid_o = (ar_cnt<BEATS) & (outstanding<MAX_OUT).
    - ar_addr_o = base + ar_cnt*STRIDE, truncated to ADDR_W; base = addr1 for TMMA, addr0 otherwise.
    - r_ready_o=1.
    - outstanding: +1 on AR handshake, −1 on R handshake, unchanged when both occur in the same cycle.
    - On the R handshake with r_cnt==BEATS-1, go to IDLE.
  - STORE:
    - aw_valid_o=res_valid_i; res_ready_o=aw_ready_i.
    - aw_data_o=res_data_i; aw_addr_o = addr0 + w_cnt*STRIDE.
    - On the handshake with w_cnt==BEATS-1, go to IDLE.
- Outside LOAD: ar_valid_o=0, r_ready_o=0. Outside STORE: aw_valid_o=0, res_ready_o=0.
- PRELOADA:
  - Each R beat writes A buffer bank wr_bank=~rd_bank at address r_cnt. No feed.
  - On the last beat: rd_bank<=wr_bank, a_valid<=1.
- TMMA: each R beat gives feed_valid_o=1 in the same cycle, combinationally:
  - feed_top_data_o=r_data_i.
  - feed_left_data_o = bank rd_bank[r_cnt], or 0 if a_valid=0.
  - feed_type_o=0; feed_cnt_o=r_cnt.
- PRELOADC: each R beat gives feed_valid_o=1, feed_left_data_o=r_data_i, feed_top_data_o=0, feed_type_o=1.
- done_o pulses in the IDLE cycle that follows the final handshake. tinst_ready_o is high in that same cycle.
- A PRELOADA may overlap a later TMMA only through the bank swap; a TMMA always reads the most recently completed PRELOADA.
- Counters wrap to 0 on completion; there is no overflow beyond BEATS.
- The A buffer is not reset; only a_valid qualifies it.
- Reset mid-operation aborts immediately. Any in-flight R beats arriving after reset are ignored because r_ready_o=0.

Optional Feature:
- Macro SARRAY_LDST_PERF_EN.
- When defined, add outputs perf_busy_o [31:0] and perf_ar_stall_o [31:0]:
  - perf_busy_o counts cycles with state≠IDLE.
  - perf_ar_stall_o counts LOAD cycles with ar_cnt<BEATS but ar_valid_o&ar_ready_i=0, including cycles blocked by the MAX_OUT limit.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- When not defined, these ports and counters are absent.

Test Plan:
1. PRELOADA addr0=0x1000, BEATS=64, ar_ready/r_valid always 1 → AR addresses 0x1000..0x4F00 step 0x100; feed_valid_o stays 0; done_o pulses once; next TMMA uses the new bank.
2. PRELOADA rows k=value k, then TMMA addr1=0x8000 with r_data=~k → 64 feed beats with left=k, top=~k, cnt=k, type=0; done_o pulses once.
3. TMMA immediately after reset (a_valid=0) → feed_left_data_o=0 on all 64 beats.
4. MAX_OUT=8, r_valid held 0 for 20 cycles → exactly 8 AR handshakes, then ar_valid_o=0 until R beats return.
5. STOREC addr0=0x2000, res_valid toggling, aw_ready random → 64 writes with aw_addr=0x2000+k*0x100 and data in order; res_ready_o mirrors aw_ready_i.
6. rst_n asserted at beat 30 of a TMMA → all outputs at reset values asynchronously; tinst_ready_o=1 after release; a_valid=0.
